// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock and carries between chunks through a register.
// Optional flag logic (overflow, zero) is enabled by defining SEQ_CHUNK_ADDER_FLAGS_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry_reg;
    logic [IDXW-1:0]   idx;

    int                base;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              last;

    // One CHUNK-wide slice of the operation, selected by the running chunk index.
    assign base    = int'(idx) * CHUNK;
    assign chunk_a = op_a[base +: CHUNK];
    assign chunk_b = op_b[base +: CHUNK];
    assign {chunk_cout, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_reg};
    assign last    = (idx == IDXW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1, so b is inverted and the carry seeded here.
                        op_a      <= a;
                        op_b      <= b ^ {WIDTH{sub}};
                        carry_reg <= sub | cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[base +: CHUNK] <= chunk_sum;
                    carry_reg          <= chunk_cout;
                    idx                <= idx + 1'b1;
                    if (last) begin
                        carry <= chunk_cout;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
    logic             msb_cin;
    logic [WIDTH-1:0] sum_next;

    // Carry into the MSB is recovered from the top bit of the final chunk.
    assign msb_cin = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];

    always_comb begin
        sum_next               = sum;
        sum_next[base +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == S_RUN && last) begin
            overflow <= msb_cin ^ chunk_cout;
            zero     <= (sum_next == '0);
        end
    end
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: three instances (CHUNK=8, 1, 32) against an arithmetic reference model.
module tb_seq_chunk_adder;

    localparam int LAT [3] = '{4, 32, 1};

    logic        clk;
    logic        rst;
    logic        start [3];
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy_v [3];
    logic        done_v [3];
    logic [31:0] sum_v [3];
    logic        carry_v [3];
    logic        ovf_v [3];
    logic        zero_v [3];

    int n_cmp;
    int n_err;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .carry(carry_v[0]),
        .overflow(ovf_v[0]), .zero(zero_v[0])
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .carry(carry_v[1]),
        .overflow(ovf_v[1]), .zero(zero_v[1])
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .carry(carry_v[2]),
        .overflow(ovf_v[2]), .zero(zero_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, signed overflow from operand and result signs.
    function automatic res_t model(input logic [31:0] pa, input logic [31:0] pb,
                                   input logic ps, input logic pc);
        res_t        r;
        logic [31:0] bb;
        logic [32:0] full;
        bb   = ps ? ~pb : pb;
        full = {1'b0, pa} + {1'b0, bb} + {32'd0, (ps ? 1'b1 : pc)};
        r.s  = full[31:0];
        r.c  = full[32];
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
        r.v  = (pa[31] == bb[31]) && (r.s[31] != pa[31]);
        r.z  = (r.s == 32'd0);
`else
        r.v  = 1'b0;
        r.z  = 1'b0;
`endif
        return r;
    endfunction

    task automatic run_op(input int u, input logic [31:0] pa, input logic [31:0] pb,
                          input logic ps, input logic pc, input string tag);
        res_t exp;
        int   cnt;
        exp = model(pa, pb, ps, pc);
        @(negedge clk);
        a = pa; b = pb; sub = ps; cin = pc; start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        n_cmp++;
        if (busy_v[u] !== 1'b1) begin
            n_err++; $display("[TB] FAIL %s u%0d busy_after_accept: got %b expected 1", tag, u, busy_v[u]);
        end
        cnt = 0;
        while (done_v[u] !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        n_cmp++;
        if (cnt !== LAT[u]) begin
            n_err++; $display("[TB] FAIL %s u%0d latency: got %0d expected %0d", tag, u, cnt, LAT[u]);
        end
        n_cmp++;
        if (sum_v[u] !== exp.s || carry_v[u] !== exp.c || ovf_v[u] !== exp.v || zero_v[u] !== exp.z) begin
            n_err++;
            $display("[TB] FAIL %s u%0d result: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                     tag, u, sum_v[u], carry_v[u], ovf_v[u], zero_v[u], exp.s, exp.c, exp.v, exp.z);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || sum_v[u] !== exp.s || carry_v[u] !== exp.c) begin
            n_err++;
            $display("[TB] FAIL %s u%0d after_done: got done=%b busy=%b s=%h c=%b expected done=0 busy=0 s=%h c=%b",
                     tag, u, done_v[u], busy_v[u], sum_v[u], carry_v[u], exp.s, exp.c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        for (int u = 0; u < 3; u++) begin
            n_cmp++;
            if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 || sum_v[u] !== 32'd0 ||
                carry_v[u] !== 1'b0 || ovf_v[u] !== 1'b0 || zero_v[u] !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL reset u%0d: got busy=%b done=%b s=%h c=%b v=%b z=%b expected all zero",
                         u, busy_v[u], done_v[u], sum_v[u], carry_v[u], ovf_v[u], zero_v[u]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        for (int u = 0; u < 3; u++) begin
            run_op(u, 32'd2147483648, 32'd1073741824, 1'b0, 1'b0, "add_big");
            run_op(u, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, "wrap_zero");
            run_op(u, 32'd5, 32'd7, 1'b1, 1'b0, "sub_borrow");
            run_op(u, 32'd7, 32'd5, 1'b1, 1'b1, "sub_noborrow");
            run_op(u, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, "signed_ovf");
            run_op(u, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, "cin_ripple");
        end
    endtask

    // A start pulse held during RUN must not queue a second operation.
    task automatic test_ignore_start();
        res_t        exp;
        int          dones;
        logic [31:0] got;
        exp = model(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        dones = 0;
        got = '0;
        @(negedge clk);
        a = 32'h7FFFFFFF; b = 32'd1; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                start[0] = 1'b1; a = 32'd0; b = 32'd0;
            end
            if (c == 3) start[0] = 1'b0;
            @(posedge clk); #1;
            if (done_v[0] === 1'b1) begin
                dones++; got = sum_v[0];
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++; $display("[TB] FAIL ignore_start done_count: got %0d expected 1", dones);
        end
        n_cmp++;
        if (got !== exp.s || sum_v[0] !== exp.s || busy_v[0] !== 1'b0) begin
            n_err++; $display("[TB] FAIL ignore_start result: got s=%h held=%h busy=%b expected s=%h busy=0",
                              got, sum_v[0], busy_v[0], exp.s);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        run_op(0, 32'd2147483648, 32'd1073741824, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || sum_v[0] !== 32'd0 || carry_v[0] !== 1'b0) begin
            n_err++; $display("[TB] FAIL mid_reset outputs: got busy=%b done=%b s=%h c=%b expected 0 0 0 0",
                              busy_v[0], done_v[0], sum_v[0], carry_v[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++; $display("[TB] FAIL mid_reset no_done: got %0d active cycles expected 0", dones);
        end
        run_op(0, 32'd7, 32'd5, 1'b1, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        int reps [3] = '{20, 6, 20};
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < reps[u]; i++) begin
                run_op(u, $urandom, $urandom, 1'($urandom), 1'($urandom), "random");
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(0, $urandom, $urandom, 1'(i), 1'(i >> 1), "back_to_back");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
